// File: rtl/radix_pkg.sv
// Shared definitions for the digit-serial radix adder: FSM encoding, default
// geometry and the digit-counter width helper.
package radix_pkg;

    localparam int DEFAULT_M      = 4;
    localparam int DEFAULT_R_BITS = 4;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    // A single-digit configuration still needs a one-bit counter.
    function automatic int cntWidth(input int m);
        return (m <= 1) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/radix_digit_add.sv
// One radix-2^R_BITS digit cell: add or subtract a digit pair with carry.
// With RADIX_SERIAL_BCD_EN defined, an i_bcd input selects decimal correction.
module radix_digit_add
    import radix_pkg::*;
#(
    parameter int R_BITS = DEFAULT_R_BITS
) (
    input  logic [R_BITS-1:0] i_a,
    input  logic [R_BITS-1:0] i_b,
    input  logic              i_carry,
    input  logic              i_sub,
`ifdef RADIX_SERIAL_BCD_EN
    input  logic              i_bcd,
`endif
    output logic [R_BITS-1:0] o_digit,
    output logic              o_carry
);

    logic [R_BITS-1:0] w_bEff;
    logic [R_BITS:0]   w_raw;

`ifdef RADIX_SERIAL_BCD_EN
    logic [R_BITS-1:0] w_decDigit;

    // Decimal subtraction uses the nine's complement instead of bit inversion.
    always_comb begin
        if (i_bcd) begin
            w_bEff = i_sub ? (R_BITS'(9) - i_b) : i_b;
        end else begin
            w_bEff = i_sub ? ~i_b : i_b;
        end
    end

    assign w_raw      = {1'b0, i_a} + {1'b0, w_bEff} + {{R_BITS{1'b0}}, i_carry};
    assign w_decDigit = w_raw[R_BITS-1:0] + R_BITS'(6);

    always_comb begin
        o_digit = w_raw[R_BITS-1:0];
        o_carry = w_raw[R_BITS];
        if (i_bcd && (w_raw > (R_BITS+1)'(9))) begin
            o_digit = w_decDigit;
            o_carry = 1'b1;
        end
    end
`else
    assign w_bEff  = i_sub ? ~i_b : i_b;
    assign w_raw   = {1'b0, i_a} + {1'b0, w_bEff} + {{R_BITS{1'b0}}, i_carry};
    assign o_digit = w_raw[R_BITS-1:0];
    assign o_carry = w_raw[R_BITS];
`endif

endmodule

// File: rtl/radix_serial_adder.sv
// Digit-serial adder/subtractor: one digit per clock, LSB first, with
// valid/ready on both sides. Optional decimal mode under RADIX_SERIAL_BCD_EN.
module radix_serial_adder
    import radix_pkg::*;
#(
    parameter int M      = DEFAULT_M,
    parameter int R_BITS = DEFAULT_R_BITS
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [R_BITS*M-1:0] x,
    input  logic [R_BITS*M-1:0] y,
    input  logic                cin,
    input  logic                sub,
`ifdef RADIX_SERIAL_BCD_EN
    input  logic                bcd,
`endif
    output logic                out_valid,
    input  logic                out_ready,
    output logic [R_BITS*M-1:0] sum,
    output logic                cout,
    output logic                busy
);

    localparam int W  = R_BITS * M;
    localparam int CW = cntWidth(M);

    logic [1:0]        r_state;
    logic [CW-1:0]     r_count;
    logic [W-1:0]      r_x;
    logic [W-1:0]      r_y;
    logic [W-1:0]      r_sum;
    logic              r_carry;
    logic              r_sub;
    logic              r_cout;
    logic [31:0]       w_base;
    logic [R_BITS-1:0] w_digit;
    logic              w_carry;
    logic              w_last;

`ifdef RADIX_SERIAL_BCD_EN
    logic              r_bcd;
`endif

    assign w_base = 32'(r_count) * 32'(R_BITS);
    assign w_last = (r_count == CW'(M - 1));

    radix_digit_add #(
        .R_BITS (R_BITS)
    ) u_digit (
        .i_a     (r_x[w_base +: R_BITS]),
        .i_b     (r_y[w_base +: R_BITS]),
        .i_carry (r_carry),
        .i_sub   (r_sub),
`ifdef RADIX_SERIAL_BCD_EN
        .i_bcd   (r_bcd),
`endif
        .o_digit (w_digit),
        .o_carry (w_carry)
    );

    // Subtraction runs as x + ~y + ~cin, so the chain starts from the inverted borrow.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_count <= '0;
            r_x     <= '0;
            r_y     <= '0;
            r_sum   <= '0;
            r_carry <= 1'b0;
            r_sub   <= 1'b0;
            r_cout  <= 1'b0;
`ifdef RADIX_SERIAL_BCD_EN
            r_bcd   <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_x     <= x;
                        r_y     <= y;
                        r_sub   <= sub;
                        r_carry <= sub ? ~cin : cin;
`ifdef RADIX_SERIAL_BCD_EN
                        r_bcd   <= bcd;
`endif
                        r_count <= '0;
                        r_state <= S_RUN;
                    end
                end
                S_RUN: begin
                    r_sum[w_base +: R_BITS] <= w_digit;
                    r_carry                 <= w_carry;
                    if (w_last) begin
                        r_cout  <= w_carry;
                        r_state <= S_DONE;
                    end else begin
                        r_count <= r_count + 1'b1;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign in_ready  = (r_state == S_IDLE);
    assign out_valid = (r_state == S_DONE);
    assign busy      = (r_state == S_RUN) || (r_state == S_DONE);
    assign sum       = r_sum;
    assign cout      = r_cout;

endmodule
